// File: rtl/vga_raster_gen.sv
// vga_raster_gen: 640x480@60 VGA raster timing with down-scaled 160x120 pixel coordinates
//
// Ports:
//   VGA_CLK      in   system/pixel clock, all state on the rising edge
//   resetn       in   asynchronous active-low reset
//   VGA_HS       out  horizontal sync, active low
//   VGA_VS       out  vertical sync, active low
//   VGA_BLANK_N  out  1 on visible pixels, 0 during blanking
//   xvga         out  scaled column (hcount >> SCALE_SHIFT), 0 while blanked
//   yvga         out  scaled row (vcount >> SCALE_SHIFT), 0 while blanked
//   pixel_tick   out  one-cycle pulse per raster advance (constant 1 when CLK_DIV = 1)
//   frame_start  out  one-cycle pulse on the first cycle that presents pixel (0,0)
//
// Define VGA_OUT_PIPE_EN to add one more register stage on every output (latency 2),
// keeping all outputs aligned with each other and with identical reset values.
module vga_raster_gen #(
  parameter int H_VISIBLE   = 640,
  parameter int H_FRONT     = 16,
  parameter int H_SYNC      = 96,
  parameter int H_BACK      = 48,
  parameter int V_VISIBLE   = 480,
  parameter int V_FRONT     = 10,
  parameter int V_SYNC      = 2,
  parameter int V_BACK      = 33,
  parameter int SCALE_SHIFT = 2,
  parameter int CLK_DIV     = 1
) (
  input  logic       VGA_CLK,
  input  logic       resetn,
  output logic       VGA_HS,
  output logic       VGA_VS,
  output logic       VGA_BLANK_N,
  output logic [7:0] xvga,
  output logic [6:0] yvga,
  output logic       pixel_tick,
  output logic       frame_start
);
  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int HW = $clog2(H_TOTAL);
  localparam int VW = $clog2(V_TOTAL);
  localparam int DW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
  localparam logic [19:0] OUT_RST = {1'b1, 1'b1, 18'd0};
  logic [DW-1:0] div;
  logic [HW-1:0] hcount;
  logic [VW-1:0] vcount;
  logic          adv;
  logic          h_end;
  logic          v_end;
  logic          vis;
  logic          hs_n;
  logic          vs_n;
  logic          fs;
  logic [HW-1:0] hs_scaled;
  logic [VW-1:0] vs_scaled;
  logic [19:0]   dec;
  logic [19:0]   stage1;
  logic [19:0]   out_vec;
  assign adv   = div == DW'(CLK_DIV - 1);
  assign h_end = hcount == HW'(H_TOTAL - 1);
  assign v_end = vcount == VW'(V_TOTAL - 1);
  always_ff @(posedge VGA_CLK or negedge resetn) begin
    if (!resetn) begin
      div    <= '0;
      hcount <= '0;
      vcount <= '0;
    end else begin
      div <= adv ? '0 : div + 1'b1;
      if (adv) begin
        hcount <= h_end ? '0 : hcount + 1'b1;
        if (h_end) vcount <= v_end ? '0 : vcount + 1'b1;
      end
    end
  end
  // Comparisons are done at 32 bits so range limits equal to a power of two cannot wrap.
  assign vis       = 32'(hcount) < H_VISIBLE && 32'(vcount) < V_VISIBLE;
  assign hs_n      = !(32'(hcount) >= H_VISIBLE + H_FRONT && 32'(hcount) < H_VISIBLE + H_FRONT + H_SYNC);
  assign vs_n      = !(32'(vcount) >= V_VISIBLE + V_FRONT && 32'(vcount) < V_VISIBLE + V_FRONT + V_SYNC);
  assign hs_scaled = hcount >> SCALE_SHIFT;
  assign vs_scaled = vcount >> SCALE_SHIFT;
  // Only the first divider phase of pixel (0,0) flags the frame, so the pulse stays one cycle wide.
  assign fs        = div == '0 && hcount == '0 && vcount == '0;
  assign dec = {hs_n, vs_n, vis, vis ? 8'(hs_scaled) : 8'd0, vis ? 7'(vs_scaled) : 7'd0, adv, fs};
  always_ff @(posedge VGA_CLK or negedge resetn) begin
    if (!resetn) stage1 <= OUT_RST;
    else stage1 <= dec;
  end
`ifdef VGA_OUT_PIPE_EN
  logic [19:0] stage2;
  always_ff @(posedge VGA_CLK or negedge resetn) begin
    if (!resetn) stage2 <= OUT_RST;
    else stage2 <= stage1;
  end
  assign out_vec = stage2;
`else
  assign out_vec = stage1;
`endif
  assign {VGA_HS, VGA_VS, VGA_BLANK_N, xvga, yvga, pixel_tick, frame_start} = out_vec;
endmodule
